park_gate_controller: RTL and testbench

Entry/exit gate controller for the 8-space parking lot. It produces the `park_number` and `pattern` pair consumed by `token_production`: `park_number` is the lowest free space and `pattern` is a per-car value from a free-running LFSR. It records occupancy and each space's pattern. On exit it validates the presented token against the stored pattern, frees the space and times the gate opening.

---
 rtl/park_gate_controller.sv | 159 +++++++++++++++
 tb/tb_park_gate_controller.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/park_gate_controller.sv
// park_gate_controller
//
// Entry/exit gate controller for an 8-space parking lot. On entry it assigns
// the lowest free space and a per-car pattern taken from a free-running 3-bit
// LFSR, and remembers that pattern for the space. On exit it checks the token
// presented for the claimed space against the stored pattern. A valid token
// frees the space and opens the gate; an invalid token is rejected.
//
// Handshake: arrive_req / leave_req are levels. The controller samples them only
// in IDLE, answers with a one-cycle grant / leave_ok / leave_err pulse, then
// refuses to return to IDLE until both requests are low again. A request that
// stays high is therefore served exactly once.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   arrive_req   car waiting at the entry (level)
//   leave_req    car waiting at the exit (level)
//   leave_slot   space number claimed by the exiting car
//   leave_token  token presented by the exiting car
//   park_number  assigned space (held until the next grant)
//   pattern      assigned pattern (held until the next grant)
//   grant        one-cycle pulse: park_number/pattern just updated
//   leave_ok     one-cycle pulse: exit accepted
//   leave_err    one-cycle pulse: exit rejected
//   gate_open    gate actuator, high for GATE_CYCLES cycles per accepted car
//   occupancy    bit i set = space i occupied
//   free_count   number of free spaces, 0..8
//   full         all spaces occupied
`timescale 1ns/1ps

module park_gate_controller #(
  parameter int unsigned GATE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       arrive_req,
  input  logic       leave_req,
  input  logic [2:0] leave_slot,
  input  logic [2:0] leave_token,
  output logic [2:0] park_number,
  output logic [2:0] pattern,
  output logic       grant,
  output logic       leave_ok,
  output logic       leave_err,
  output logic       gate_open,
  output logic [7:0] occupancy,
  output logic [3:0] free_count,
  output logic       full
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GATE    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state, state_next;
  logic [3:0] gate_cnt, gate_cnt_next;
  logic [2:0] lfsr;
  logic [2:0] stored_pattern [8];
  logic [7:0] occ_next;
  logic [2:0] low_free;
  logic       exit_valid;
  logic       do_grant, do_ok, do_err;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  // Lowest clear bit of occupancy; scanning downward lets the lowest index win.
  always_comb begin
    low_free = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!occupancy[i]) low_free = 3'(i);
    end
  end

  assign exit_valid = occupancy[leave_slot] &&
                      (leave_token == (leave_slot ^ stored_pattern[leave_slot]));

  assign gate_open = (state == GATE);

  always_comb begin
    state_next    = state;
    gate_cnt_next = gate_cnt;
    occ_next      = occupancy;
    do_grant      = 1'b0;
    do_ok         = 1'b0;
    do_err        = 1'b0;
    case (state)
      IDLE: begin
        // Exit takes priority over entry when both are waiting.
        if (leave_req) begin
          if (exit_valid) begin
            do_ok                = 1'b1;
            occ_next[leave_slot] = 1'b0;
            state_next           = GATE;
            gate_cnt_next        = 4'(GATE_CYCLES - 1);
          end else begin
            do_err     = 1'b1;
            state_next = RELEASE;
          end
        end else if (arrive_req && !full) begin
          do_grant           = 1'b1;
          occ_next[low_free] = 1'b1;
          state_next         = GATE;
          gate_cnt_next      = 4'(GATE_CYCLES - 1);
        end
      end
      GATE: begin
        // gate_cnt counts the remaining open cycles after the current one.
        if (gate_cnt == 4'd0) state_next = RELEASE;
        else                  gate_cnt_next = gate_cnt - 4'd1;
      end
      RELEASE: begin
        if (!arrive_req && !leave_req) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gate_cnt    <= 4'd0;
      lfsr        <= 3'b001;
      occupancy   <= 8'h00;
      free_count  <= 4'd8;
      full        <= 1'b0;
      park_number <= 3'd0;
      pattern     <= 3'd0;
      grant       <= 1'b0;
      leave_ok    <= 1'b0;
      leave_err   <= 1'b0;
      for (int i = 0; i < 8; i++) stored_pattern[i] <= 3'd0;
    end else begin
      state      <= state_next;
      gate_cnt   <= gate_cnt_next;
      lfsr       <= {lfsr[1:0], lfsr[2] ^ lfsr[1]};
      occupancy  <= occ_next;
      // Derived from the next occupancy so all three status outputs move together.
      free_count <= 4'd8 - popcount8(occ_next);
      full       <= &occ_next;
      grant      <= do_grant;
      leave_ok   <= do_ok;
      leave_err  <= do_err;
      if (do_grant) begin
        park_number              <= low_free;
        pattern                  <= lfsr;
        stored_pattern[low_free] <= lfsr;
      end
    end
  end

endmodule

// File: tb/tb_park_gate_controller.sv
`timescale 1ns/1ps

module tb_park_gate_controller;

  localparam int GC = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       arrive_req = 1'b0;
  logic       leave_req = 1'b0;
  logic [2:0] leave_slot = 3'd0;
  logic [2:0] leave_token = 3'd0;
  logic [2:0] park_number, pattern;
  logic       grant, leave_ok, leave_err, gate_open, full;
  logic [7:0] occupancy;
  logic [3:0] free_count;

  park_gate_controller #(.GATE_CYCLES(GC)) dut (
    .clk(clk), .rst_n(rst_n),
    .arrive_req(arrive_req), .leave_req(leave_req),
    .leave_slot(leave_slot), .leave_token(leave_token),
    .park_number(park_number), .pattern(pattern),
    .grant(grant), .leave_ok(leave_ok), .leave_err(leave_err),
    .gate_open(gate_open), .occupancy(occupancy),
    .free_count(free_count), .full(full)
  );

  int errors = 0;
  int checks = 0;

  // expected event word: {kind[1:0], park_number, pattern}
  // kind 01 = grant, 10 = leave_ok, 11 = leave_err
  logic [7:0] exp_q[$];

  // reference model
  logic [2:0] m_lfsr;
  logic [7:0] m_occ;
  logic [2:0] m_pat [8];
  logic [2:0] m_park, m_patt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 3'b001;
    else        m_lfsr <= {m_lfsr[1:0], m_lfsr[2] ^ m_lfsr[1]};
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: every handshake pulse pops one expectation
  always @(negedge clk) begin
    logic [7:0] obs;
    if (rst_n && (grant || leave_ok || leave_err)) begin
      obs = {leave_ok | leave_err, grant | leave_err, park_number, pattern};
      if (exp_q.size() == 0) check_eq("unexpected_evt", 32'(obs), 32'h0);
      else                   check_eq("sb_evt", 32'(obs), 32'(exp_q.pop_front()));
    end
  end

  task automatic check_status(input string tag);
    check_eq({tag, "_occ"}, 32'(occupancy), 32'(m_occ));
    check_eq({tag, "_free"}, 32'(free_count), 32'(8 - $countones(m_occ)));
    check_eq({tag, "_full"}, 32'(full), 32'(m_occ == 8'hFF));
  endtask

  task automatic wait_evt(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (grant || leave_ok || leave_err) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check_eq("evt_timeout", 32'(seen), 32'd1);
  endtask

  task automatic count_gate(input int exp_cycles);
    int n;
    n = 0;
    while (gate_open && n < 40) begin
      n++;
      @(negedge clk);
    end
    check_eq("gate_len", 32'(n), 32'(exp_cycles));
  endtask

  // driver: one entry expected to land on exp_park
  task automatic do_arrive(input logic [2:0] exp_park);
    logic [2:0] pat;
    bit seen;
    @(negedge clk);
    pat = m_lfsr;
    exp_q.push_back({2'b01, exp_park, pat});
    arrive_req = 1'b1;
    wait_evt(seen);
    arrive_req = 1'b0;
    if (seen) begin
      m_occ[exp_park] = 1'b1;
      m_pat[exp_park] = pat;
      m_park = exp_park;
      m_patt = pat;
    end
    check_status("arrive");
    count_gate(GC);
  endtask

  // driver: one exit, optional extra hold of the requests, optional concurrent arrival
  task automatic do_exit(input logic [2:0] slot, input logic [2:0] token,
                         input int hold, input bit with_arrive);
    bit valid, seen;
    @(negedge clk);
    valid = m_occ[slot] && (token == (slot ^ m_pat[slot]));
    exp_q.push_back({(valid ? 2'b10 : 2'b11), m_park, m_patt});
    leave_slot  = slot;
    leave_token = token;
    leave_req   = 1'b1;
    arrive_req  = with_arrive;
    wait_evt(seen);
    if (seen && valid) m_occ[slot] = 1'b0;
    check_status("exit");
    if (valid) count_gate(GC);
    else       check_eq("err_no_gate", 32'(gate_open), 32'd0);
    repeat (hold) @(negedge clk);
    leave_req  = 1'b0;
    arrive_req = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    m_occ = 8'h00; m_park = 3'd0; m_patt = 3'd0;
    for (int i = 0; i < 8; i++) m_pat[i] = 3'd0;

    repeat (3) @(negedge clk);
    check_eq("rst_park", 32'(park_number), 32'd0);
    check_eq("rst_pattern", 32'(pattern), 32'd0);
    check_eq("rst_pulses", 32'({grant, leave_ok, leave_err}), 32'd0);
    check_eq("rst_gate", 32'(gate_open), 32'd0);
    check_status("rst");
    rst_n = 1'b1;

    // first request sampled on the 3rd edge after release -> pattern 101
    @(negedge clk);
    do_arrive(3'd0);
    check_eq("first_pattern", 32'(pattern), 32'h5);

    for (int p = 1; p < 8; p++) do_arrive(3'(p));
    check_eq("lot_full", 32'(full), 32'd1);

    // arrival while full must not be granted
    @(negedge clk);
    arrive_req = 1'b1;
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (grant) n++;
    end
    check_eq("full_no_grant", 32'(n), 32'd0);
    arrive_req = 1'b0;

    do_exit(3'd3, 3'd3 ^ m_pat[3], 0, 1'b0);
    do_arrive(3'd3);

    do_exit(3'd0, 3'd0 ^ m_pat[0], 0, 1'b0);
    do_exit(3'd1, 3'd1 ^ m_pat[1] ^ 3'd1, 5, 1'b0);
    do_exit(3'd0, 3'd5, 0, 1'b0);

    // simultaneous requests: exit served first, then entry
    do_exit(3'd2, 3'd2 ^ m_pat[2], 0, 1'b1);
    do_arrive(3'd0);

    // reset during GATE
    @(negedge clk);
    exp_q.push_back({2'b01, 3'd2, m_lfsr});
    arrive_req = 1'b1;
    wait_evt(seen);
    arrive_req = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_gate", 32'(gate_open), 32'd1);
    rst_n = 1'b0;
    #1;
    m_occ = 8'h00;
    check_eq("midrst_gate", 32'(gate_open), 32'd0);
    check_eq("midrst_park", 32'(park_number), 32'd0);
    check_status("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
